// File: rtl/fib_seq_gen_if.sv
// Request/response bundle for fib_seq_gen: go/done handshake, job inputs,
// the final result and the live term stream.
interface fib_seq_gen_if #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32
);
    logic                    go;
    logic [INPUT_WIDTH-1:0]  n;
    logic [OUTPUT_WIDTH-1:0] a0;
    logic [OUTPUT_WIDTH-1:0] b0;
    logic                    wrap;
    logic                    busy;
    logic                    done;
    logic [OUTPUT_WIDTH-1:0] result;
    logic                    overflow;
    logic                    term_valid;
    logic [OUTPUT_WIDTH-1:0] term;
    logic [INPUT_WIDTH-1:0]  term_idx;

    modport master (
        output go, n, a0, b0, wrap,
        input  busy, done, result, overflow, term_valid, term, term_idx
    );

    modport slave (
        input  go, n, a0, b0, wrap,
        output busy, done, result, overflow, term_valid, term, term_idx
    );
endinterface

// File: rtl/fib_seq_gen.sv
// Generalised Fibonacci engine: F(k)=F(k-1)+F(k-2) from caller seeds, one term
// per clock, with a streamed term output and stop-or-wrap overflow handling.
module fib_seq_gen #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    fib_seq_gen_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

    logic [0:0]              state;
    logic [INPUT_WIDTH-1:0]  target;
    logic [INPUT_WIDTH-1:0]  cnt;
    logic [INPUT_WIDTH-1:0]  next_cnt;
    logic [OUTPUT_WIDTH-1:0] prev;
    logic [OUTPUT_WIDTH-1:0] cur;
    logic                    wrapmode;
    logic [OUTPUT_WIDTH:0]   sum;

    // The extra top bit of sum is the carry that signals overflow.
    assign sum      = {1'b0, prev} + {1'b0, cur};
    assign next_cnt = cnt + INPUT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            target         <= '0;
            cnt            <= '0;
            prev           <= '0;
            cur            <= '0;
            wrapmode       <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.result     <= '0;
            bus.overflow   <= 1'b0;
            bus.term_valid <= 1'b0;
            bus.term       <= '0;
            bus.term_idx   <= '0;
        end else begin
            bus.done       <= 1'b0;
            bus.term_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        target       <= bus.n;
                        wrapmode     <= bus.wrap;
                        bus.overflow <= 1'b0;
                        if (bus.n == '0) begin
                            bus.result <= bus.a0;
                            bus.done   <= 1'b1;
                        end else if (bus.n == INPUT_WIDTH'(1)) begin
                            bus.result <= bus.b0;
                            bus.done   <= 1'b1;
                        end else begin
                            prev       <= bus.a0;
                            cur        <= bus.b0;
                            cnt        <= INPUT_WIDTH'(1);
                            bus.result <= '0;
                            bus.busy   <= 1'b1;
                            state      <= CALC;
                        end
                    end
                end
                CALC: begin
                    // Stop policy: report the last representable term, never stream the bad one.
                    if (sum[OUTPUT_WIDTH] && !wrapmode) begin
                        bus.result   <= cur;
                        bus.overflow <= 1'b1;
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        prev           <= cur;
                        cur            <= sum[OUTPUT_WIDTH-1:0];
                        cnt            <= next_cnt;
                        bus.term_valid <= 1'b1;
                        bus.term       <= sum[OUTPUT_WIDTH-1:0];
                        bus.term_idx   <= next_cnt;
                        if (sum[OUTPUT_WIDTH]) begin
                            bus.overflow <= 1'b1;
                        end
                        if (next_cnt == target) begin
                            bus.result <= sum[OUTPUT_WIDTH-1:0];
                            bus.done   <= 1'b1;
                            bus.busy   <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/fib_seq_gen.md
# fib_seq_gen

Parametrised generalised-Fibonacci engine, successor to the fixed 0/1-seeded Fibonacci calculator. Computes term n of F(k)=F(k-1)+F(k-2) from caller-supplied seeds (Fibonacci, Lucas, any pair), one term per clock. Adds a live term stream, a busy flag, and a selectable overflow policy: stop-and-flag or wrap-and-continue. Sits behind the same go/done request style used by the existing sequence blocks.

## Interface
- INPUT_WIDTH, 6, width of term index n
- OUTPUT_WIDTH, 32, width of seeds, terms and result
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- go  in  1  start request, sampled only when busy=0
- n  in  INPUT_WIDTH  index of requested term, captured with go
- a0  in  OUTPUT_WIDTH  seed F(0), captured with go
- b0  in  OUTPUT_WIDTH  seed F(1), captured with go
- wrap  in  1  overflow policy, captured with go: 0=stop on overflow, 1=wrap modulo 2^OUTPUT_WIDTH
- busy  out  1  high while computing
- done  out  1  one-cycle completion pulse
- result  out  OUTPUT_WIDTH  final term, held until next accepted go
- overflow  out  1  overflow occurred in current/last job, held until next accepted go
- term_valid  out  1  one-cycle pulse per computed term
- term  out  OUTPUT_WIDTH  term being streamed
- term_idx  out  INPUT_WIDTH  index k of streamed term

## Operation
- States: IDLE, CALC. Reset (rst=0, any time, async): state=IDLE, all outputs 0, internal prev/cur/cnt 0.
- IDLE, go=1: capture n, a0, b0, wrap; clear overflow.
  - n=0: result=a0, done=1, stay IDLE.
  - n=1: result=b0, done=1, stay IDLE.
  - n>=2: prev=a0, cur=b0, cnt=1, busy=1, enter CALC.
- CALC each edge: sum=prev+cur as OUTPUT_WIDTH+1 bits; carry=sum[MSB].
  - No carry, or carry with wrap=1: prev=cur, cur=sum[OUTPUT_WIDTH-1:0], cnt=cnt+1; term_valid=1, term=new cur, term_idx=cnt+1; carry sets overflow (sticky).
  - If cnt+1==n: result=new cur, done=1, busy=0, return IDLE.
  - Carry with wrap=0: abort: result=cur (last valid term), overflow=1, done=1, busy=0, IDLE; overflowing term not streamed (term_valid=0).
- go while busy=1 ignored. Inputs n/a0/b0/wrap ignored except at accepted go.
- Stream emits only computed terms k=2..n; n<=1 jobs produce no term_valid.
- term/term_idx hold last value between pulses.

## Timing
- Go-sampling edge = edge 0. done, result, overflow valid in the cycle after edge max(n-1,0); n=0/1 → done in the cycle directly after go.
- busy high from after edge 0 to after the finishing edge (low in the done cycle).
- term_valid for term k high in cycle after edge k-1.
- done cycle is IDLE: go high in the done cycle is accepted (back-to-back jobs, zero bubble).
- Reset mid-CALC: outputs drop to 0 asynchronously, no done pulse; first go after rst release starts clean.
- Throughput: one term per clock; n up to 2^INPUT_WIDTH-1.

## Test plan
- a0=0, b0=1, n=10, wrap=0 → term stream 1,2,3,5,8,13,21,34,55 (idx 2..10); result=55, overflow=0, done in cycle after edge 9.
- Lucas a0=2, b0=1, n=5 → result=11; n=0 → result=2, n=1 → result=1, done in cycle after go.
- OUTPUT_WIDTH=32, a0=0, b0=1, n=50, wrap=0 → abort: result=2971215073 (F47), overflow=1, done after edge 47, last term_idx=47.
- Same with n=48, wrap=1 → result=512559680, overflow=1, done after edge 47; all 47 terms streamed.
- go pulsed mid-job with different n → ignored, first job result intact; go in done cycle → new job accepted, busy high next cycle.
- rst low mid-CALC at n=20 → busy/done/result/term_valid=0 immediately, no done pulse; next go n=3 (0,1) → result=2.
